// File: rtl/gpio_reg_host_pkg.sv
// Shared types and register offsets for the GPIO register-bus host.
package gpio_reg_host_pkg;

   typedef enum logic [1:0] {
      OpWrite   = 2'b00,
      OpRead    = 2'b01,
      OpMasked  = 2'b10,
      OpIllegal = 2'b11
   } gpio_reg_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StWrLo,
      StWrHi,
      StRdWait,
      StRsp
   } gpio_host_state_e;

   localparam logic [7:0] GPIO_DIRECT_OUT_OFF = 8'h00;
   localparam logic [7:0] GPIO_MASKED_LO_OFF  = 8'h04;
   localparam logic [7:0] GPIO_MASKED_HI_OFF  = 8'h08;

   // Masked-register beat payload: mask half in the top 16 bits, data half below.
   function automatic logic [31:0] masked_beat(input logic [15:0] mask, input logic [15:0] data);
      return {mask, data};
   endfunction

endpackage

// File: rtl/gpio_reg_host_if.sv
// Command/response handshake port between a sequencer and the GPIO register host.
interface gpio_reg_host_if;
   import gpio_reg_host_pkg::*;

   logic         cmd_valid;
   logic         cmd_ready;
   gpio_reg_op_e cmd_op;
   logic [7:0]   cmd_addr;
   logic [31:0]  cmd_wdata;
   logic [31:0]  cmd_mask;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/gpio_reg_host.sv
// Register-bus initiator for one GPIO instance: one command in flight, one response per command.
module gpio_reg_host
   import gpio_reg_host_pkg::*;
#(
   parameter int unsigned RdLatency = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   gpio_reg_host_if.slave    cmd,
   output logic              reg_we_o,
   output logic [31:0]       reg_addr_o,
   output logic [31:0]       reg_wdata_o,
   input  logic [31:0]       reg_rdata_i
);

   gpio_host_state_e state_q, state_d;
   logic        we_q, we_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        hi_pend_q, hi_pend_d;
   logic [31:0] hi_wdata_q, hi_wdata_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic accept;
   logic lo_en, hi_en;

   assign accept = cmd.cmd_valid && (state_q == StIdle);
   assign lo_en  = |cmd.cmd_mask[15:0];
   assign hi_en  = |cmd.cmd_mask[31:16];

   assign cmd.cmd_ready = (state_q == StIdle);
   assign cmd.rsp_valid = (state_q == StRsp);
   assign cmd.rsp_rdata = rsp_rdata_q;
   assign cmd.rsp_err   = rsp_err_q;
   assign reg_we_o      = we_q;
   assign reg_addr_o    = {24'h0, addr_q};
   assign reg_wdata_o   = wdata_q;

   // State and registered bus/response outputs; reset aborts any operation at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 32'h0;
         cnt_q       <= 3'd0;
         hi_pend_q   <= 1'b0;
         hi_wdata_q  <= 32'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         hi_pend_q   <= hi_pend_d;
         hi_wdata_q  <= hi_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               unique case (cmd.cmd_op)
                  OpWrite:  state_d = StWrLo;
                  OpRead:   state_d = StRdWait;
                  OpMasked: state_d = lo_en ? StWrLo : (hi_en ? StWrHi : StRsp);
                  default:  state_d = StRsp;
               endcase
            end
         end
         StWrLo:   state_d = hi_pend_q ? StWrHi : StRsp;
         StWrHi:   state_d = StRsp;
         StRdWait: if (cnt_q == 3'd0) state_d = StRsp;
         StRsp:    if (cmd.rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Next values of bus beats, read counter, captured command and response.
   always_comb begin
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      hi_pend_d   = hi_pend_q;
      hi_wdata_d  = hi_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               // Upper masked beat is captured now so later cmd changes cannot leak in.
               hi_pend_d   = (cmd.cmd_op == OpMasked) && hi_en;
               hi_wdata_d  = masked_beat(cmd.cmd_mask[31:16], cmd.cmd_wdata[31:16]);
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               unique case (cmd.cmd_op)
                  OpWrite: begin
                     we_d    = 1'b1;
                     addr_d  = cmd.cmd_addr;
                     wdata_d = cmd.cmd_wdata;
                  end
                  OpRead: begin
                     addr_d = cmd.cmd_addr;
                     cnt_d  = 3'(RdLatency);
                  end
                  OpMasked: begin
                     if (lo_en) begin
                        we_d    = 1'b1;
                        addr_d  = GPIO_MASKED_LO_OFF;
                        wdata_d = masked_beat(cmd.cmd_mask[15:0], cmd.cmd_wdata[15:0]);
                     end else if (hi_en) begin
                        we_d    = 1'b1;
                        addr_d  = GPIO_MASKED_HI_OFF;
                        wdata_d = masked_beat(cmd.cmd_mask[31:16], cmd.cmd_wdata[31:16]);
                     end
                  end
                  default: rsp_err_d = 1'b1;
               endcase
            end
         end
         StWrLo: begin
            if (hi_pend_q) begin
               we_d    = 1'b1;
               addr_d  = GPIO_MASKED_HI_OFF;
               wdata_d = hi_wdata_q;
            end
         end
         StRdWait: begin
            if (cnt_q == 3'd0) rsp_rdata_d = reg_rdata_i;
            else               cnt_d = cnt_q - 3'd1;
         end
         default: ;
      endcase
   end

endmodule
